// File: rtl/counter_param.sv
// Parametrised up/down counter with step, saturate and load modes.
// Registered Q plus one-cycle rco/err pulses and a sat level flag.
module counter_param #(
  parameter int WIDTH   = 4,
  parameter int STEP    = 3,
  parameter int MAX_VAL = 2**WIDTH-1
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             enable,
  input  logic [2:0]       modo,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             rco,
  output logic             sat,
  output logic             err
);

  localparam logic [2:0] M_UP1  = 3'b000;
  localparam logic [2:0] M_DN1  = 3'b001;
  localparam logic [2:0] M_UPN  = 3'b010;
  localparam logic [2:0] M_LOAD = 3'b011;
  localparam logic [2:0] M_SUP  = 3'b100;
  localparam logic [2:0] M_SDN  = 3'b101;
  localparam logic [2:0] M_HOLD = 3'b110;
  localparam logic [2:0] M_RSV  = 3'b111;

  // One extra bit so Q+STEP and MAX_VAL+1 never truncate.
  localparam logic [WIDTH:0] MAX_X  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] MOD_X  = (WIDTH+1)'(MAX_VAL + 1);
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] ZERO_Q = '0;

  logic [WIDTH-1:0] q_nxt;
  logic             rco_nxt;
  logic             sat_nxt;
  logic             err_nxt;
  logic [WIDTH:0]   sum_x;
  logic [WIDTH:0]   d_x;

  // Next-state and flag decode for the sampled mode.
  always_comb begin
    q_nxt   = Q;
    rco_nxt = 1'b0;
    sat_nxt = 1'b0;
    err_nxt = 1'b0;
    sum_x   = {1'b0, Q} + STEP_X;
    d_x     = {1'b0, D};
    if (enable) begin
      unique case (modo)
        M_UP1: begin
          rco_nxt = (Q == MAX_Q);
          q_nxt   = rco_nxt ? ZERO_Q : Q + 1'b1;
        end
        M_DN1: begin
          rco_nxt = (Q == ZERO_Q);
          q_nxt   = rco_nxt ? MAX_Q : Q - 1'b1;
        end
        M_UPN: begin
          rco_nxt = (sum_x > MAX_X);
          q_nxt   = rco_nxt ? WIDTH'(sum_x - MOD_X)
                            : WIDTH'(sum_x);
        end
        M_LOAD: begin
          if (d_x > MAX_X) begin
            q_nxt   = MAX_Q;
            err_nxt = 1'b1;
          end else begin
            q_nxt   = D;
            rco_nxt = (D == MAX_Q);
          end
        end
        M_SUP: begin
          q_nxt   = (Q == MAX_Q) ? MAX_Q : Q + 1'b1;
          sat_nxt = (q_nxt == MAX_Q);
        end
        M_SDN: begin
          q_nxt   = (Q == ZERO_Q) ? ZERO_Q : Q - 1'b1;
          sat_nxt = (q_nxt == ZERO_Q);
        end
        M_HOLD: begin
          q_nxt = Q;
        end
        M_RSV: begin
          err_nxt = 1'b1;
        end
      endcase
    end
  end

  // Output registers; reset discards any in-flight count.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      Q   <= '0;
      rco <= 1'b0;
      sat <= 1'b0;
      err <= 1'b0;
    end else begin
      Q   <= q_nxt;
      rco <= rco_nxt;
      sat <= sat_nxt;
      err <= err_nxt;
    end
  end

endmodule

// File: tb/tb_counter_param.sv
// Bench for counter_param: default (0..15) and decade (0..9) instances
// driven together, checked against constants and an arithmetic model.
module tb_counter_param;

  logic       clk;
  logic       reset_L;
  logic       enable;
  logic [2:0] modo;
  logic [3:0] d;

  logic [3:0] q_def, q_dec;
  logic       rco_def, sat_def, err_def;
  logic       rco_dec, sat_dec, err_dec;

  int checks = 0;
  int errors = 0;

  int mq_def, mr_def, ms_def, me_def;
  int mq_dec, mr_dec, ms_dec, me_dec;

  counter_param u_def (
    .clk(clk), .reset_L(reset_L), .enable(enable), .modo(modo),
    .D(d), .Q(q_def), .rco(rco_def), .sat(sat_def), .err(err_def)
  );

  counter_param #(.MAX_VAL(9)) u_dec (
    .clk(clk), .reset_L(reset_L), .enable(enable), .modo(modo),
    .D(d), .Q(q_dec), .rco(rco_dec), .sat(sat_dec), .err(err_dec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference behaviour from plain integer arithmetic.
  task automatic ref_next(input int mx, input int q, input int en,
                          input int md, input int dv,
                          output int nq, output int r,
                          output int s, output int e);
    nq = q; r = 0; s = 0; e = 0;
    if (en != 0) begin
      case (md)
        0: begin nq = (q + 1) % (mx + 1); r = (q + 1 > mx) ? 1 : 0; end
        1: begin nq = (q == 0) ? mx : q - 1; r = (q == 0) ? 1 : 0; end
        2: begin nq = (q + 3) % (mx + 1); r = (q + 3 > mx) ? 1 : 0; end
        3: begin
          if (dv > mx) begin nq = mx; e = 1; end
          else begin nq = dv; r = (dv == mx) ? 1 : 0; end
        end
        4: begin nq = (q + 1 > mx) ? mx : q + 1; s = (nq == mx) ? 1 : 0; end
        5: begin nq = (q - 1 < 0) ? 0 : q - 1; s = (nq == 0) ? 1 : 0; end
        6: nq = q;
        default: begin nq = q; e = 1; end
      endcase
    end
  endtask

  task automatic model_reset();
    mq_def = 0; mr_def = 0; ms_def = 0; me_def = 0;
    mq_dec = 0; mr_dec = 0; ms_dec = 0; me_dec = 0;
  endtask

  // One clock: drive at negedge, advance model, return 1 after posedge.
  task automatic cyc(input logic en, input logic [2:0] m,
                     input logic [3:0] dv);
    int nq, r, s, e;
    @(negedge clk);
    enable = en; modo = m; d = dv;
    ref_next(15, mq_def, int'(en), int'(m), int'(dv), nq, r, s, e);
    mq_def = nq; mr_def = r; ms_def = s; me_def = e;
    ref_next(9, mq_dec, int'(en), int'(m), int'(dv), nq, r, s, e);
    mq_dec = nq; mr_dec = r; ms_dec = s; me_dec = e;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_L = 1'b0; enable = 1'b1; modo = 3'b000; d = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({q_def, rco_def, sat_def, err_def} !== 7'd0) begin
      errors++;
      $display("FAIL reset_def: got %b expected 0", {q_def, rco_def, sat_def, err_def});
    end
    checks++;
    if ({q_dec, rco_dec, sat_dec, err_dec} !== 7'd0) begin
      errors++;
      $display("FAIL reset_dec: got %b expected 0", {q_dec, rco_dec, sat_dec, err_dec});
    end
    @(negedge clk);
    enable = 1'b0; reset_L = 1'b1;
    model_reset();
    cyc(1'b1, 3'b011, 4'd7);
    checks++;
    if (q_def !== 4'd7) begin
      errors++;
      $display("FAIL reset_preload: Q=%0d expected 7", q_def);
    end
    #2;
    reset_L = 1'b0;
    #1;
    checks++;
    if (q_def !== 4'd0 || q_dec !== 4'd0) begin
      errors++;
      $display("FAIL reset_async: Q=%0d/%0d expected 0", q_def, q_dec);
    end
    @(negedge clk);
    enable = 1'b0; reset_L = 1'b1;
    model_reset();
  endtask

  task automatic test_up_down();
    int exq[5] = '{15, 0, 1, 0, 15};
    int exr[5] = '{0, 1, 0, 0, 1};
    cyc(1'b1, 3'b011, 4'd14);
    checks++;
    if (q_def !== 4'd14 || rco_def !== 1'b0) begin
      errors++;
      $display("FAIL load14: Q=%0d rco=%0b expected 14/0", q_def, rco_def);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, (i < 3) ? 3'b000 : 3'b001, 4'd0);
      checks++;
      if (q_def !== 4'(exq[i]) || rco_def !== 1'(exr[i])) begin
        errors++;
        $display("FAIL updown[%0d]: Q=%0d rco=%0b expected %0d/%0d",
                 i, q_def, rco_def, exq[i], exr[i]);
      end
    end
  endtask

  task automatic test_upn();
    cyc(1'b1, 3'b011, 4'd12);
    cyc(1'b1, 3'b010, 4'd0);
    checks++;
    if (q_def !== 4'd15 || rco_def !== 1'b0) begin
      errors++;
      $display("FAIL upn_1: Q=%0d rco=%0b expected 15/0", q_def, rco_def);
    end
    cyc(1'b1, 3'b010, 4'd0);
    checks++;
    if (q_def !== 4'd2 || rco_def !== 1'b1) begin
      errors++;
      $display("FAIL upn_2: Q=%0d rco=%0b expected 2/1", q_def, rco_def);
    end
  endtask

  task automatic test_decade();
    cyc(1'b1, 3'b011, 4'd13);
    checks++;
    if (q_dec !== 4'd9 || err_dec !== 1'b1 || rco_dec !== 1'b0) begin
      errors++;
      $display("FAIL dec_load13: Q=%0d err=%0b rco=%0b expected 9/1/0",
               q_dec, err_dec, rco_dec);
    end
    cyc(1'b1, 3'b011, 4'd8);
    cyc(1'b1, 3'b010, 4'd0);
    checks++;
    if (q_dec !== 4'd1 || rco_dec !== 1'b1) begin
      errors++;
      $display("FAIL dec_upn: Q=%0d rco=%0b expected 1/1", q_dec, rco_dec);
    end
    for (int i = 0; i < 100; i++) begin
      cyc(1'b1, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      checks++;
      if (q_dec > 4'd9 || q_dec !== 4'(mq_dec)) begin
        errors++;
        $display("FAIL dec_range[%0d]: Q=%0d expected %0d (<=9)",
                 i, q_dec, mq_dec);
      end
    end
  endtask

  task automatic test_sat();
    cyc(1'b1, 3'b011, 4'd14);
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 3'b100, 4'd0);
      checks++;
      if (q_def !== 4'd15 || sat_def !== 1'b1 || rco_def !== 1'b0) begin
        errors++;
        $display("FAIL sat_up[%0d]: Q=%0d sat=%0b rco=%0b expected 15/1/0",
                 i, q_def, sat_def, rco_def);
      end
    end
    cyc(1'b1, 3'b011, 4'd1);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 3'b101, 4'd0);
      checks++;
      if (q_def !== 4'd0 || sat_def !== 1'b1 || rco_def !== 1'b0) begin
        errors++;
        $display("FAIL sat_dn[%0d]: Q=%0d sat=%0b rco=%0b expected 0/1/0",
                 i, q_def, sat_def, rco_def);
      end
    end
  endtask

  task automatic test_enable_illegal();
    cyc(1'b1, 3'b011, 4'd5);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
      checks++;
      if (q_def !== 4'd5 || {rco_def, sat_def, err_def} !== 3'b000) begin
        errors++;
        $display("FAIL en0[%0d]: Q=%0d flags=%b expected 5/000",
                 i, q_def, {rco_def, sat_def, err_def});
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 3'b111, 4'd0);
      checks++;
      if (q_def !== 4'd5 || {rco_def, sat_def, err_def} !== 3'b001) begin
        errors++;
        $display("FAIL rsv[%0d]: Q=%0d flags=%b expected 5/001",
                 i, q_def, {rco_def, sat_def, err_def});
      end
    end
    cyc(1'b1, 3'b110, 4'd0);
    checks++;
    if (q_def !== 4'd5 || {rco_def, sat_def, err_def} !== 3'b000) begin
      errors++;
      $display("FAIL hold: Q=%0d flags=%b expected 5/000",
               q_def, {rco_def, sat_def, err_def});
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
          4'($urandom_range(0, 15)));
      checks++;
      if ({q_def, rco_def, sat_def, err_def} !==
          {4'(mq_def), 1'(mr_def), 1'(ms_def), 1'(me_def)}) begin
        errors++;
        $display("FAIL rand_def[%0d]: got Q=%0d r/s/e=%b expected %0d %0d%0d%0d",
                 i, q_def, {rco_def, sat_def, err_def},
                 mq_def, mr_def, ms_def, me_def);
      end
      checks++;
      if ({q_dec, rco_dec, sat_dec, err_dec} !==
          {4'(mq_dec), 1'(mr_dec), 1'(ms_dec), 1'(me_dec)}) begin
        errors++;
        $display("FAIL rand_dec[%0d]: got Q=%0d r/s/e=%b expected %0d %0d%0d%0d",
                 i, q_dec, {rco_dec, sat_dec, err_dec},
                 mq_dec, mr_dec, ms_dec, me_dec);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_up_down();
    test_upn();
    test_decade();
    test_sat();
    test_enable_illegal();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/counter_param.md
Name: counter_param

Overview:
- Parametrised successor of the team's 4-bit mode counter: generic-width, programmable-modulus up/down counter.
- Adds step-by-N, saturating modes, parallel load with range check, registered ripple-carry (rco), saturation and error flags.
- Drop-in count/timebase block for the project datapath; cascades via rco into the next stage's enable.

Parameters:
WIDTH, 4, bit width of D and Q.
STEP, 3, increment applied in step mode; legal range 1..MAX_VAL.
MAX_VAL, 2**WIDTH-1, terminal count; counting range is 0..MAX_VAL (MAX_VAL=9 gives a decade counter).

Ports:
clk  input  1  rising-edge clock.
reset_L  input  1  asynchronous reset, active-low.
enable  input  1  count/load qualifier; sampled on rising clk.
modo  input  3  operating mode, sampled with enable.
D  input  WIDTH  parallel load value.
Q  output  WIDTH  counter value, registered.
rco  output  1  registered one-cycle pulse on wrap or terminal load.
sat  output  1  registered; high while a saturating mode is clamped at its bound.
err  output  1  registered one-cycle pulse on illegal mode or out-of-range load.

Behaviour:
- Reset: reset_L low at any time immediately forces Q=0, rco=0, sat=0, err=0, regardless of clk. Reset mid-count discards the in-flight value. The first count occurs on the first rising clk after reset_L rises.
- All outputs are registered. Latency is 1 cycle from the sampled inputs to the Q/rco/sat/err update.
- enable=0: Q holds; rco, sat and err are 0 on the next edge.
- enable=1, by modo:
  - 000 up1: Q = (Q==MAX_VAL) ? 0 : Q+1; rco=1 when the wrap occurs.
  - 001 down1: Q = (Q==0) ? MAX_VAL : Q-1; rco=1 when the wrap occurs.
  - 010 upN: Q = (Q+STEP) mod (MAX_VAL+1), computed at WIDTH+1 bits with no truncation before the compare. rco=1 when Q+STEP > MAX_VAL.
  - 011 load: Q = D; rco=1 when D==MAX_VAL. If D > MAX_VAL, Q = MAX_VAL and err=1 (rco=0).
  - 100 sat-up: Q = min(Q+1, MAX_VAL); sat=1 on every edge where the result equals MAX_VAL; never wraps; rco=0.
  - 101 sat-down: Q = max(Q-1, 0); sat=1 on every edge where the result equals 0; never wraps; rco=0.
  - 110 hold: Q holds; rco=0, sat=0.
  - 111 reserved: Q holds; err=1; rco=0, sat=0.
- rco and err are never high longer than the cycle after the causing edge unless the cause repeats on consecutive edges. Example: continuous up1 with MAX_VAL=0 gives rco=1 on every edge.
- sat is 0 whenever the sampled mode is not 100/101 or enable=0.
- Q is always within 0..MAX_VAL after reset. Q > MAX_VAL is unreachable and must never be observed.
- Mode change takes effect on the same edge it is sampled; there is no pipeline flush.

Test Plan:
- Reset: hold reset_L=0 across 3 clk with enable=1, modo=000 → Q=0, rco=0, sat=0, err=0. Assert reset_L low asynchronously mid-cycle at Q=7 → Q=0 before the next edge.
- Defaults (WIDTH=4, MAX_VAL=15): load D=14, then up1 ×3 → Q=15, 0, 1; rco=1 only in the cycle Q=0. Then down1 ×2 → Q=0, 15; rco=1 with Q=15.
- upN, STEP=3: load 12, then upN ×2 → Q=15 (rco=0), then Q=2 (rco=1).
- Decade (MAX_VAL=9): load 13 → Q=9, err=1, rco=0. upN from 8 with STEP=3 → Q=1, rco=1. Q never exceeds 9 over 100 random enabled cycles.
- Saturation: from 14, sat-up ×3 → Q=15, 15, 15 with sat=1,1,1 and rco=0. From 1, sat-down ×2 → Q=0, 0 with sat=1,1.
- Enable/illegal: enable=0 with any modo for 5 cycles → Q constant, flags 0. modo=111 with enable=1 → Q constant, err one-cycle pulse per sampled edge. modo=110 → Q constant, no flags.
